// File: rtl/load_store_unit_if.sv
// Purpose : bundle of CPU request/response and word-memory signals for load_store_unit.
// Ports   : master = CPU/memory environment side, slave = load_store_unit side.
//           req_*  request handshake and payload (CPU -> LSU), req_ready back
//           rsp_*  one-cycle response pulse with error flag and load data
//           mem_*  single-port word memory (combinational read, synchronous write)
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Purpose : load/store unit between the CPU datapath and a single-port big-endian
//           word memory. Byte/half/word loads with sign/zero extension, word stores
//           in one memory cycle, sub-word stores by read-modify-write, and error
//           responses for misaligned / reserved-size requests.
// Ports   : clk, rst (async, active-high), bus (load_store_unit_if.slave):
//           req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata,
//           rsp_valid/rsp_err/rsp_rdata, mem_addr/mem_we/mem_wdata/mem_rdata.
// Config  : define LSU_RANGE_CHECK_EN to reject addresses with any bit set above
//           the memory's byte address space; otherwise those bits are ignored and
//           the address wraps.
module load_store_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

  state_e              state_q,     state_d;
  logic                we_q,        we_d;
  logic [1:0]          size_q,      size_d;
  logic                signed_q,    signed_d;
  logic [1:0]          off_q,       off_d;
  logic [HALF_W-1:0]   wdata_q,     wdata_d;     // only sub-word stores merge from here
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic                mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;  // also serves as the RMW merge buffer

  logic                req_bad_c;

  // Select the big-endian lane for a load and extend it to a full word.
  function automatic logic [DATA_W-1:0] load_lane(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] sz,
                                                  input logic [1:0] off,
                                                  input logic sgn);
    logic [7:0]        b;
    logic [HALF_W-1:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: load_lane = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_lane = {{16{sgn & h[15]}}, h};
      default: load_lane = w;
    endcase
  endfunction

  // Replace the addressed byte/half of the current memory word with store data.
  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] w,
                                                   input logic [HALF_W-1:0] wd,
                                                   input logic [1:0] sz,
                                                   input logic [1:0] off);
    merge_lane = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    merge_lane[31:24] = wd[7:0];
        2'd1:    merge_lane[23:16] = wd[7:0];
        2'd2:    merge_lane[15:8]  = wd[7:0];
        default: merge_lane[7:0]   = wd[7:0];
      endcase
    end else if (off[1]) begin
      merge_lane[15:0] = wd;
    end else begin
      merge_lane[31:16] = wd;
    end
  endfunction

  // Request legality: size/alignment, plus the optional upper-address check.
  always_comb begin
    req_bad_c = (bus.req_size == SZ_RSVD)
              | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
              | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]));
`ifdef LSU_RANGE_CHECK_EN
    req_bad_c = req_bad_c | (bus.req_addr[31:ADDR_W+2] != '0);
`endif
  end

`ifndef LSU_RANGE_CHECK_EN
  // Upper address bits wrap away when the range check is not built in.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          signed_d    = bus.req_signed;
          off_d       = bus.req_addr[1:0];
          wdata_d     = bus.req_wdata[HALF_W-1:0];
          rsp_err_d   = req_bad_c;
          rsp_rdata_d = '0;
          if (req_bad_c) begin
            state_d = RESP;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = bus.req_addr[ADDR_W+1:2];
            // Word stores write during ACCESS, so their strobe is set up now.
            if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = bus.req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rsp_rdata_d = load_lane(bus.mem_rdata, size_q, off_q, signed_q);
          state_d     = RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = RESP;
        end else begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_lane(bus.mem_rdata, wdata_q, size_q, off_q);
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : self-checking bench for load_store_unit. Provides the word memory,
//           drives directed and random requests, and compares responses, latency,
//           write strobes and memory contents against an arithmetic reference model.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory seen by the DUT and the model's independent copy.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] last_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: expected outcome of one request, updating ref_mem for stores.
  task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic e_err, output logic [31:0] e_rdata,
                       output int e_lat, output int e_we, output int widx);
    logic [31:0] w, v, mask;
    int k, sh;
    k     = int'(addr % 4);
    widx  = int'((addr / 4) % DEPTH);
    w     = ref_mem[widx];
    e_err = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)
            || (RANGE_CHK && addr >= 32'(4 * DEPTH));
    e_rdata = 32'd0;
    e_we    = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      if (sz == 2'd0) begin
        v = (w >> (8 * (3 - k))) & 32'hFF;
        if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (w >> (16 * (1 - k / 2))) & 32'hFFFF;
        if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      e_rdata = v;
    end else begin
      e_we  = 1;
      e_lat = (sz == 2'd2) ? 2 : 3;
      if (sz == 2'd2) begin
        w = wd;
      end else begin
        sh   = (sz == 2'd0) ? 8 * (3 - k) : 16 * (1 - k / 2);
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        w    = (w & ~mask) | ((wd << sh) & mask);
      end
      ref_mem[widx] = w;
    end
  endtask

  // One complete request: wait for ready, accept, watch the response window.
  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         input bit garbage);
    logic        e_err, got_err;
    logic [31:0] e_rdata, got_rdata;
    int          e_lat, e_we, widx, lat, we_cnt, wd_bad;
    model(we, sz, sgn, addr, wd, e_err, e_rdata, e_lat, e_we, widx);
    @(negedge clk);
    for (int i = 0; i < 8 && !bus.req_ready; i++) @(negedge clk);
    check_eq({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    // Junk held on the request while busy must be neither accepted nor latched.
    bus.req_valid  = garbage;
    bus.req_we     = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0; we_cnt = 0; wd_bad = 0; got_err = 1'b0; got_rdata = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.mem_we) we_cnt++;
      else if (bus.mem_wdata != 32'd0) wd_bad++;
      if (bus.rsp_valid) begin
        lat = c; got_err = bus.rsp_err; got_rdata = bus.rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    last_rdata    = got_rdata;
    check_eq({tag, "/latency"}, 32'(lat), 32'(e_lat));
    check_eq({tag, "/err"}, 32'(got_err), 32'(e_err));
    check_eq({tag, "/rdata"}, got_rdata, e_rdata);
    check_eq({tag, "/we_pulses"}, 32'(we_cnt), 32'(e_we));
    check_eq({tag, "/wdata_idle"}, 32'(wd_bad), 32'd0);
    check_eq({tag, "/mem"}, mem[widx], ref_mem[widx]);
    @(posedge clk); #1;
    check_eq({tag, "/pulse_end"}, {30'd0, bus.rsp_valid, bus.mem_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, v;
    logic [1:0]  sz;
    int          rsp_seen;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      mem[i] = v; ref_mem[i] = v;
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/ready",    32'(bus.req_ready), 32'd1);
    check_eq("reset/rsp",      {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check_eq("reset/rdata",    bus.rsp_rdata, 32'd0);
    check_eq("reset/mem_we",   32'(bus.mem_we), 32'd0);
    check_eq("reset/mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("reset/mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Word store then load back.
    run_req("t1_sw", 1'b1, 2'd2, 1'b0, 32'h028, 32'hAAAA_AAAA, 1'b0);
    run_req("t1_lw", 1'b0, 2'd2, 1'b0, 32'h028, 32'd0, 1'b1);
    check_eq("t1/value", last_rdata, 32'hAAAA_AAAA);

    // Byte store by read-modify-write.
    mem[10] = 32'h1122_3344; ref_mem[10] = 32'h1122_3344;
    run_req("t2_sb", 1'b1, 2'd0, 1'b0, 32'h029, 32'h0000_00EE, 1'b0);
    check_eq("t2/word", mem[10], 32'h11EE_3344);

    // Sign/zero extension.
    mem[10] = 32'h80FF_7F01; ref_mem[10] = 32'h80FF_7F01;
    run_req("t3_lb", 1'b0, 2'd0, 1'b1, 32'h028, 32'd0, 1'b0);
    check_eq("t3/lb", last_rdata, 32'hFFFF_FF80);
    run_req("t3_lbu", 1'b0, 2'd0, 1'b0, 32'h029, 32'd0, 1'b0);
    check_eq("t3/lbu", last_rdata, 32'h0000_00FF);
    run_req("t3_lh", 1'b0, 2'd1, 1'b1, 32'h02A, 32'd0, 1'b0);
    check_eq("t3/lh", last_rdata, 32'h0000_7F01);

    // Misaligned requests.
    run_req("t4_lw", 1'b0, 2'd2, 1'b0, 32'h02A, 32'd0, 1'b0);
    run_req("t4_sh", 1'b1, 2'd1, 1'b0, 32'h029, 32'h1234_5678, 1'b0);
    check_eq("t4/word", mem[10], 32'h80FF_7F01);

    // Reset while an sb is in WRITE.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h029; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("t5/we_before", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t5/we_after", 32'(bus.mem_we), 32'd0);
    check_eq("t5/ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) rsp_seen++;
    end
    check_eq("t5/no_rsp", 32'(rsp_seen), 32'd0);
    check_eq("t5/word", mem[10], ref_mem[10]);

    // Address above the memory's byte space.
    run_req("t6_lw", 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) a = (sz == 2'd1) ? (a & ~32'd1) : (sz == 2'd2) ? (a & ~32'd3) : a;
      run_req($sformatf("rnd%0d", n), 1'($urandom), sz, 1'($urandom), a, $urandom,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
